// File: rtl/hc_pkg.sv
// Shared sizing and types for the host read-response reorder buffer.
package hc_pkg;

  localparam int ROB_TAG_WIDTH  = 6;
  localparam int ROB_DEPTH      = 1 << ROB_TAG_WIDTH;
  localparam int ROB_DATA_WIDTH = 512;

  typedef logic [ROB_TAG_WIDTH-1:0]  t_rob_tag;
  typedef logic [ROB_DATA_WIDTH-1:0] t_rob_data;

endpackage

// File: rtl/hc_rob_ram.sv
// Reorder-buffer payload store: one synchronous write port, combinational read at the head.
// No reset: slot validity is tracked by the owner, so stale contents are never observed.
module hc_rob_ram
  import hc_pkg::*;
#(
  parameter int DATA_WIDTH = ROB_DATA_WIDTH,
  parameter int TAG_WIDTH  = ROB_TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [TAG_WIDTH-1:0]  wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_dat_i,
  input  logic [TAG_WIDTH-1:0]  rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_dat_o
);

  logic [DATA_WIDTH-1:0] mem_q [1 << TAG_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/hc_read_reorder.sv
// Returns out-of-order read responses in issue order; one output register, head response to out_valid in 1 cycle.
// out_valid/out_data hold while !out_ready; allocation stalls when all DEPTH tags are outstanding.
module hc_read_reorder
  import hc_pkg::*;
#(
  parameter int DATA_WIDTH = ROB_DATA_WIDTH,
  parameter int TAG_WIDTH  = ROB_TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alloc_req,
  output logic                  alloc_ack,
  output logic [TAG_WIDTH-1:0]  alloc_tag,
  input  logic                  rsp_valid,
  input  logic [TAG_WIDTH-1:0]  rsp_tag,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [31:0]           out_count,
  output logic [TAG_WIDTH:0]    occupancy,
  output logic                  err_tag
);

  localparam int DEPTH = 1 << TAG_WIDTH;
  localparam logic [TAG_WIDTH:0] FULL_OCC = {1'b1, {TAG_WIDTH{1'b0}}};

  logic [TAG_WIDTH-1:0]  head_q, head_d, tail_q, tail_d;
  logic [TAG_WIDTH:0]    occ_q, occ_d;
  logic [DEPTH-1:0]      slot_vld_q, slot_vld_d;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;
  logic [31:0]           out_cnt_q, out_cnt_d;
  logic                  err_q, err_d;

  logic                  full, rsp_alloc, rsp_ok, head_bypass, head_rdy, out_free, load;
  logic [TAG_WIDTH-1:0]  rsp_off;
  logic [DATA_WIDTH-1:0] ram_rd_dat;

  assign full      = (occ_q == FULL_OCC);
  assign alloc_ack = alloc_req && !full;
  assign alloc_tag = tail_q;

  // A tag is live iff its distance from head falls inside the outstanding window.
  assign rsp_off     = rsp_tag - head_q;
  assign rsp_alloc   = ({1'b0, rsp_off} < occ_q);
  assign rsp_ok      = rsp_valid && rsp_alloc && !slot_vld_q[rsp_tag];
  assign head_bypass = rsp_ok && (rsp_tag == head_q);
  assign head_rdy    = slot_vld_q[head_q] || head_bypass;
  assign out_free    = !out_vld_q || out_ready;
  assign load        = out_free && head_rdy;

  hc_rob_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (rsp_ok),
    .wr_addr_i (rsp_tag),
    .wr_dat_i  (rsp_data),
    .rd_addr_i (head_q),
    .rd_dat_o  (ram_rd_dat)
  );

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    slot_vld_d = slot_vld_q;
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    out_cnt_d  = out_cnt_q;
    err_d      = err_q;

    if (alloc_ack) begin
      tail_d = tail_q + TAG_WIDTH'(1);
    end
    if (rsp_valid && !rsp_ok) begin
      err_d = 1'b1;
    end
    if (rsp_ok) begin
      slot_vld_d[rsp_tag] = 1'b1;
    end

    // Clearing after the set means a bypassed head response never lingers in the valid map.
    if (load) begin
      out_vld_d          = 1'b1;
      out_dat_d          = slot_vld_q[head_q] ? ram_rd_dat : rsp_data;
      slot_vld_d[head_q] = 1'b0;
      head_d             = head_q + TAG_WIDTH'(1);
      out_cnt_d          = out_cnt_q + 32'd1;
    end else if (out_free) begin
      out_vld_d = 1'b0;
    end

    case ({alloc_ack, load})
      2'b10:   occ_d = occ_q + (TAG_WIDTH+1)'(1);
      2'b01:   occ_d = occ_q - (TAG_WIDTH+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      slot_vld_q <= '0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      slot_vld_q <= slot_vld_d;
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      out_cnt_q  <= out_cnt_d;
      err_q      <= err_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;
  assign out_count = out_cnt_q;
  assign occupancy = occ_q;
  assign err_tag   = err_q;

endmodule

// File: tb/tb_hc_read_reorder.sv
// Scoreboard bench for hc_read_reorder: issue-order expectations queued at allocation, checked at delivery.
module tb_hc_read_reorder;

  logic         clk;
  logic         reset_n;
  logic         alloc_req;
  logic         alloc_ack;
  logic [5:0]   alloc_tag;
  logic         rsp_valid;
  logic [5:0]   rsp_tag;
  logic [511:0] rsp_data;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_data;
  logic [31:0]  out_count;
  logic [6:0]   occupancy;
  logic         err_tag;

  hc_read_reorder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .alloc_req (alloc_req),
    .alloc_ack (alloc_ack),
    .alloc_tag (alloc_tag),
    .rsp_valid (rsp_valid),
    .rsp_tag   (rsp_tag),
    .rsp_data  (rsp_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .occupancy (occupancy),
    .err_tag   (err_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_chk = 0;
  int           n_err = 0;
  logic [511:0] exp_q [$];
  logic [5:0]   pend [$];
  int           tag_seq [64];
  logic [5:0]   tb_tail = '0;
  int           seq = 0;
  int           issued = 0;
  int           delivered = 0;
  int           dlv_since_rst = 0;
  logic         last_ack;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] dat(input int k);
    logic [31:0] w;
    w = (k * 32'h9E37_79B9) ^ 32'h1234_5678;
    return {16{w}};
  endfunction

  // One cycle: sample at mid-cycle, update scoreboard, then step past the next rising edge.
  task automatic tick();
    #4;
    last_ack = alloc_ack;
    if (reset_n) begin
      if (alloc_req && alloc_ack) begin
        chk("alloc_tag", 512'(alloc_tag), 512'(tb_tail));
        tag_seq[tb_tail] = seq;
        exp_q.push_back(dat(seq));
        pend.push_back(tb_tail);
        seq++;
        issued++;
        tb_tail = tb_tail + 6'd1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 512'(out_valid), 512'(0));
        else chk("order", out_data, exp_q.pop_front());
        delivered++;
        dlv_since_rst++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_req = 1'b1;
      tick();
      chk("alloc_ack", 512'(last_ack), 512'(1));
    end
    alloc_req = 1'b0;
  endtask

  task automatic respond(input logic [5:0] t, input bit dup);
    rsp_valid = 1'b1;
    rsp_tag   = t;
    rsp_data  = dup ? ~dat(tag_seq[t]) : dat(tag_seq[t]);
    if (!dup) begin
      for (int i = 0; i < pend.size(); i++) begin
        if (pend[i] == t) begin
          pend.delete(i);
          break;
        end
      end
    end
    tick();
    rsp_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    while (pend.size() > 0) respond(pend[0], 1'b0);
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) tick();
    chk("drain_empty", 512'(exp_q.size()), 512'(0));
  endtask

  task automatic do_reset();
    alloc_req = 1'b0;
    rsp_valid = 1'b0;
    reset_n   = 1'b0;
    exp_q.delete();
    pend.delete();
    tb_tail       = '0;
    dlv_since_rst = 0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [5:0]   base;
    logic [5:0]   t;
    logic [5:0]   old_tag;
    logic [511:0] held;
    int           d0;
    int           i0;
    int           idx;

    reset_n   = 1'b0;
    alloc_req = 1'b1;
    rsp_valid = 1'b0;
    rsp_tag   = '0;
    rsp_data  = '0;
    out_ready = 1'b1;

    // Reset state with alloc_req high: ack is combinational, nothing else may move.
    #3;
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_out_data", out_data, 512'(0));
    chk("rst_out_count", 512'(out_count), 512'(0));
    chk("rst_occupancy", 512'(occupancy), 512'(0));
    chk("rst_err_tag", 512'(err_tag), 512'(0));
    chk("rst_alloc_ack", 512'(alloc_ack), 512'(1));
    chk("rst_alloc_tag", 512'(alloc_tag), 512'(0));
    alloc_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_out_valid", 512'(out_valid), 512'(0));
    end

    // In order: one-cycle latency, no bubbles.
    alloc_n(4);
    d0 = delivered;
    for (int i = 0; i < 4; i++) respond(pend[0], 1'b0);
    chk("inord_streaming", 512'(delivered - d0), 512'(3));
    chk("inord_out_count", 512'(out_count), 512'(4));
    chk("inord_occupancy", 512'(occupancy), 512'(0));
    tick();
    chk("inord_delivered", 512'(delivered - d0), 512'(4));
    chk("inord_idle", 512'(out_valid), 512'(0));

    // Reverse order: nothing until the head tag, then a solid burst of 8.
    alloc_n(8);
    base = pend[0];
    d0   = delivered;
    for (int i = 7; i >= 1; i--) begin
      t = base + 6'(i);
      respond(t, 1'b0);
      chk("rev_wait", 512'(out_valid), 512'(0));
    end
    respond(base, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("rev_burst", 512'(out_valid), 512'(1));
      tick();
    end
    chk("rev_delivered", 512'(delivered - d0), 512'(8));
    chk("rev_idle", 512'(out_valid), 512'(0));

    // Full and backpressure.
    out_ready = 1'b0;
    alloc_n(64);
    chk("full_occupancy", 512'(occupancy), 512'(64));
    alloc_req = 1'b1;
    tick();
    chk("full_ack", 512'(last_ack), 512'(0));
    alloc_req = 1'b0;
    base = pend[0];
    for (int i = 63; i >= 1; i--) begin
      t = base + 6'(i);
      respond(t, 1'b0);
    end
    chk("full_no_out", 512'(out_valid), 512'(0));
    respond(base, 1'b0);
    chk("full_loaded", 512'(out_valid), 512'(1));
    chk("full_occ_after_load", 512'(occupancy), 512'(63));
    alloc_req = 1'b1;
    tick();
    chk("realloc_ack", 512'(last_ack), 512'(1));
    alloc_req = 1'b0;
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 512'(out_valid), 512'(1));
      chk("bp_data", out_data, held);
    end
    chk("bp_occupancy", 512'(occupancy), 512'(64));
    out_ready = 1'b1;
    alloc_req = 1'b1;
    tick();
    chk("bp_ack_still_full", 512'(last_ack), 512'(0));
    tick();
    chk("bp_ack_returns", 512'(last_ack), 512'(1));
    alloc_req = 1'b0;
    drain();

    // Random reorder window with random backpressure across many wraps.
    d0 = delivered;
    i0 = issued;
    for (int c = 0; c < 6000 && ((issued - i0) < 200 || pend.size() > 0); c++) begin
      alloc_req = ((issued - i0) < 200) && (pend.size() < 16) && ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      if (pend.size() > 0 && $urandom_range(1) == 1) begin
        idx       = $urandom_range(pend.size() - 1);
        t         = pend[idx];
        rsp_valid = 1'b1;
        rsp_tag   = t;
        rsp_data  = dat(tag_seq[t]);
        pend.delete(idx);
      end else begin
        rsp_valid = 1'b0;
      end
      tick();
    end
    rsp_valid = 1'b0;
    alloc_req = 1'b0;
    drain();
    chk("wrap_issued", 512'(issued - i0), 512'(200));
    chk("wrap_delivered", 512'(delivered - d0), 512'(200));
    chk("wrap_out_count", 512'(out_count), 512'(dlv_since_rst));
    chk("wrap_err_tag", 512'(err_tag), 512'(0));

    // Unallocated tag.
    d0        = delivered;
    rsp_valid = 1'b1;
    rsp_tag   = 6'd5;
    rsp_data  = '1;
    tick();
    rsp_valid = 1'b0;
    chk("unalloc_err", 512'(err_tag), 512'(1));
    chk("unalloc_no_out", 512'(out_valid), 512'(0));
    tick();
    chk("unalloc_no_out2", 512'(out_valid), 512'(0));
    chk("unalloc_delivered", 512'(delivered - d0), 512'(0));
    chk("unalloc_occupancy", 512'(occupancy), 512'(0));

    // Duplicate response keeps the first payload.
    do_reset();
    chk("reset_clears_err", 512'(err_tag), 512'(0));
    out_ready = 1'b0;
    alloc_n(2);
    base = pend[0];
    t    = pend[1];
    respond(t, 1'b0);
    chk("dup_first_ok", 512'(err_tag), 512'(0));
    respond(t, 1'b1);
    chk("dup_err", 512'(err_tag), 512'(1));
    respond(base, 1'b0);
    drain();
    chk("dup_count", 512'(out_count), 512'(2));

    // Mid-stream reset drops in-flight state; stale tags then flag errors.
    out_ready = 1'b0;
    alloc_n(4);
    respond(pend[0], 1'b0);
    respond(pend[0], 1'b0);
    chk("mid_valid", 512'(out_valid), 512'(1));
    chk("mid_occupancy", 512'(occupancy), 512'(3));
    old_tag = pend[0];
    reset_n = 1'b0;
    tick();
    chk("mid_rst_occupancy", 512'(occupancy), 512'(0));
    chk("mid_rst_out_valid", 512'(out_valid), 512'(0));
    chk("mid_rst_out_count", 512'(out_count), 512'(0));
    chk("mid_rst_err", 512'(err_tag), 512'(0));
    exp_q.delete();
    pend.delete();
    tb_tail       = '0;
    dlv_since_rst = 0;
    reset_n       = 1'b1;
    out_ready     = 1'b1;
    tick();
    rsp_valid = 1'b1;
    rsp_tag   = old_tag;
    rsp_data  = dat(tag_seq[old_tag]);
    tick();
    rsp_valid = 1'b0;
    chk("stale_err", 512'(err_tag), 512'(1));
    chk("stale_no_out", 512'(out_valid), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
